// File: rtl/fetch_buffer.sv
// Eight-entry instruction queue between the PC stage and decode, with drop-and-refetch replay.
// Define FETCH_BUFFER_BYPASS_EN to forward the first instruction of a packet straight out when empty.
module fetch_buffer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst0,
  input  logic [31:0] in_inst1,
  input  logic        in_taken,
  input  logic        in_taken_slot0,
  output logic        in_allowin,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_taken,
  input  logic        out_ready,
  output logic        set_pc_from_PRIV,
  output logic [31:0] pc_from_PRIV
);

  typedef enum logic {StNormal, StReplay} state_e;

  state_e      state_q;
  logic [3:0]  count_q;
  logic [2:0]  rd_ptr_q;
  logic [2:0]  wr_ptr_q;
  logic [31:0] replay_pc_q;

  logic [31:0] pc_mem   [8];
  logic [31:0] inst_mem [8];
  logic [7:0]  taken_mem;

  logic        one_slot;
  logic [3:0]  nslots;
  logic [31:0] first_pc, first_inst, second_pc;
  logic        first_taken;
  logic        head_valid, deq, bypass_used;
  logic [3:0]  count_after;
  logic        room, pc_match, accept;
  logic        enq_first, enq_second;
  logic [3:0]  n_enq;
  logic [31:0] wr_a_pc, wr_a_inst;
  logic        wr_a_taken, wr_a_en, wr_b_en;

  // A packet starting at slot 1, or taken in slot 0, contributes a single instruction.
  always_comb begin
    one_slot    = in_pc[2] | (in_taken & in_taken_slot0);
    nslots      = one_slot ? 4'd1 : 4'd2;
    first_pc    = in_pc;
    first_inst  = in_pc[2] ? in_inst1 : in_inst0;
    first_taken = one_slot & in_taken;
    second_pc   = {in_pc[31:3], 3'b100};
  end

  assign head_valid = (count_q != 4'd0);
  assign deq        = head_valid & out_ready;
  assign in_allowin = (state_q == StNormal) && (count_q <= 4'd6);

`ifdef FETCH_BUFFER_BYPASS_EN
  logic bypass;
  assign bypass      = (count_q == 4'd0) && (state_q == StNormal) && !flush && in_valid;
  assign bypass_used = bypass & out_ready;
  always_comb begin
    out_valid = head_valid | bypass;
    out_pc    = bypass ? first_pc    : pc_mem[rd_ptr_q];
    out_inst  = bypass ? first_inst  : inst_mem[rd_ptr_q];
    out_taken = bypass ? first_taken : taken_mem[rd_ptr_q];
  end
`else
  assign bypass_used = 1'b0;
  always_comb begin
    out_valid = head_valid;
    out_pc    = pc_mem[rd_ptr_q];
    out_inst  = inst_mem[rd_ptr_q];
    out_taken = taken_mem[rd_ptr_q];
  end
`endif

  always_comb begin
    count_after = count_q - {3'b000, deq};
    room        = (count_after + nslots) <= 4'd8;
    pc_match    = (in_pc == replay_pc_q);
    accept      = in_valid && room && ((state_q == StNormal) || pc_match);
    enq_first   = accept && !bypass_used;
    enq_second  = accept && !one_slot;
    n_enq       = {3'b000, enq_first} + {3'b000, enq_second};
    // Port A takes the first instruction unless it was bypassed, then the second lands there.
    wr_a_en     = enq_first | enq_second;
    wr_b_en     = enq_first & enq_second;
    wr_a_pc     = enq_first ? first_pc    : second_pc;
    wr_a_inst   = enq_first ? first_inst  : in_inst1;
    wr_a_taken  = enq_first ? first_taken : in_taken;
  end

  // Entry contents are never reset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_a_en) begin
      pc_mem[wr_ptr_q]    <= wr_a_pc;
      inst_mem[wr_ptr_q]  <= wr_a_inst;
      taken_mem[wr_ptr_q] <= wr_a_taken;
    end
    if (wr_b_en) begin
      pc_mem[wr_ptr_q + 3'd1]    <= second_pc;
      inst_mem[wr_ptr_q + 3'd1]  <= in_inst1;
      taken_mem[wr_ptr_q + 3'd1] <= in_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q          <= StNormal;
      count_q          <= 4'd0;
      rd_ptr_q         <= 3'd0;
      wr_ptr_q         <= 3'd0;
      replay_pc_q      <= 32'd0;
      set_pc_from_PRIV <= 1'b0;
      pc_from_PRIV     <= 32'd0;
    end else if (flush) begin
      state_q          <= StNormal;
      count_q          <= 4'd0;
      rd_ptr_q         <= 3'd0;
      wr_ptr_q         <= 3'd0;
      set_pc_from_PRIV <= 1'b0;
    end else begin
      count_q          <= count_after + n_enq;
      rd_ptr_q         <= rd_ptr_q + {2'b00, deq};
      wr_ptr_q         <= wr_ptr_q + n_enq[2:0];
      set_pc_from_PRIV <= 1'b0;
      unique case (state_q)
        StNormal: begin
          if (in_valid && !accept) begin
            state_q          <= StReplay;
            set_pc_from_PRIV <= 1'b1;
            pc_from_PRIV     <= in_pc;
            replay_pc_q      <= in_pc;
          end
        end
        StReplay: begin
          if (in_valid && pc_match) begin
            if (accept) begin
              state_q <= StNormal;
            end else begin
              set_pc_from_PRIV <= 1'b1;
              pc_from_PRIV     <= replay_pc_q;
            end
          end
        end
        default: state_q <= StNormal;
      endcase
    end
  end

endmodule
